// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage: PC, in-order imem requests, tagged instruction FIFO
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (trap misaligned redirects instead of masking them)
module riscv_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misaligned
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [31:0]     data_mem [FIFO_DEPTH];

  logic            misaligned_q;
  logic [XLEN-1:0] target_pc;
  logic            grant;
  logic            resp;
  logic            drop;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_next;
  logic [CW:0]     in_use;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_pc = redirect_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      misaligned_q <= |redirect_pc[1:0];
    end
  end
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign target_pc           = {redirect_pc[XLEN-1:2], 2'b00};
  assign misaligned_q        = 1'b0;
`endif

  assign fetch_misaligned = misaligned_q;

  // Buffered plus in-flight words never exceed the FIFO, so a response always has a slot.
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req  = !reset && enable && !misaligned_q && (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = {fetch_pc[XLEN-1:2], 2'b00};

  assign grant = imem_req && imem_gnt;
  assign resp  = imem_rvalid && (outstanding != '0);
  assign drop  = resp && (discard != '0);
  assign push  = resp && (discard == '0) && !redirect_valid;
  assign pop   = inst_valid && inst_ready;

  assign outstanding_next = outstanding + CW'(grant) - CW'(resp);

  assign inst_valid = (fifo_count != '0);
  assign inst_data  = data_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        discard  <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_STEP;
        if (push)  resp_pc  <= resp_pc + PC_STEP;
        if (drop)  discard  <= discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= resp_pc;
        data_mem[wr_ptr] <= imem_rdata;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - scoreboard bench for riscv_fetch_unit with an in-order memory model
module tb_riscv_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          grants = 0;
  int          pops = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic        exp_flag = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
  endfunction

  // Memory: in-order responses, each due a random latency after its grant.
  always @(posedge clk) begin
    cyc++;
    #1;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  end

  // Monitor: the decoder must see target, target+4, ... after each redirect/reset.
  always @(negedge clk) begin
    req_t        r;
    logic [31:0] nxt;
    check("misaligned_flag", fetch_misaligned, exp_flag);
    if (reset) begin
      restart(32'h0);
      exp_flag = 1'b0;
    end else begin
      if (imem_req && imem_gnt) begin
        grants++;
        r.addr = imem_addr;
        r.due  = cyc + int'($urandom_range(lat_min, lat_max));
        mem_q.push_back(r);
      end
      if (inst_valid && inst_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %0h, no instruction expected", inst_pc);
        end else begin
          check("pop_pc", inst_pc, exp_q[0]);
          check("pop_data", inst_data, word_of(exp_q[0]));
          nxt = exp_q[0] + 32'd4;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_q.push_back(nxt);
        end
      end
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_flag = (redirect_pc[1:0] != 2'b00);
        if (exp_flag) exp_q.delete();
        else restart(redirect_pc);
`else
        restart({redirect_pc[31:2], 2'b00});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (inst_valid) return;
    end
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for inst_valid", name);
  endtask

  task automatic wait_inflight(input string name, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (mem_q.size() >= n) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for %0d in flight", name, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] rp;
    enable = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_req", imem_req, 1'b0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_valid", inst_valid, 1'b0);
    check("reset_data", inst_data, 32'h0);
    check("reset_pc", inst_pc, 32'h0);
    check("reset_flag", fetch_misaligned, 1'b0);

    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (inst_valid) break;
    end
    check("fill_latency", n, 2);

    repeat (20) tick();
    @(negedge clk);
    check("stall_grants", grants, 4);
    check("stall_req", imem_req, 1'b0);
    check("stall_head_pc", inst_pc, 32'h0);
    tick();
    inst_ready = 1'b1;
    repeat (30) tick();
    pops = 0;
    repeat (10) tick();
    check("throughput", pops, 10);

    lat_min = 3;
    lat_max = 3;
    wait_inflight("lat3_inflight", 2, 50);
    redirect_to(32'h100);
    wait_valid("lat3_redirect", 50);
    check("lat3_first_pc", inst_pc, 32'h100);

    tick();
    lat_min = 1;
    lat_max = 1;
    repeat (10) tick();
    for (int i = 0; i < 50; i++) begin
      if (imem_req && inst_valid) break;
      tick();
    end
    check("same_cycle_setup", imem_req && inst_valid, 1'b1);
    redirect_to(32'h40);
    wait_valid("same_cycle_redirect", 50);
    check("same_cycle_first_pc", inst_pc, 32'h40);

    tick();
    repeat (5) tick();
    redirect_to(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (5) tick();
    @(negedge clk);
    check("misalign_flag_set", fetch_misaligned, 1'b1);
    check("misalign_req_blocked", imem_req, 1'b0);
    check("misalign_fifo_empty", inst_valid, 1'b0);
    tick();
    redirect_to(32'h200);
    wait_valid("misalign_recover", 50);
    check("misalign_recover_pc", inst_pc, 32'h200);
    check("misalign_flag_clear", fetch_misaligned, 1'b0);
`else
    wait_valid("misalign_masked", 50);
    check("misalign_masked_pc", inst_pc, 32'h100);
    check("misalign_flag_tied", fetch_misaligned, 1'b0);
`endif

    tick();
    lat_min = 4;
    lat_max = 4;
    wait_inflight("burst_inflight", 3, 50);
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("midreset_req", imem_req, 1'b0);
    check("midreset_addr", imem_addr, 32'h0);
    check("midreset_valid", inst_valid, 1'b0);
    check("midreset_data", inst_data, 32'h0);
    check("midreset_pc", inst_pc, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20 && mem_q.size() != 0; i++) tick();
    repeat (2) tick();
    @(negedge clk);
    check("stray_drained", mem_q.size(), 0);
    check("stray_ignored", inst_valid, 1'b0);
    tick();
    lat_min = 1;
    lat_max = 1;
    enable  = 1'b1;
    wait_valid("restart_after_reset", 50);
    check("restart_pc", inst_pc, 32'h0);
    check("restart_data", inst_data, word_of(32'h0));

    tick();
    gnt_pct = 70;
    lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        rp = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
        redirect_to(rp);
      end else begin
        tick();
      end
    end
    inst_ready = 1'b1;
    enable     = 1'b1;
    redirect_to(32'h300);
    wait_valid("final_redirect", 50);
    check("final_pc", inst_pc, 32'h300);
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised instruction-fetch stage that replaces the bare program-counter-plus-combinational-memory path of the single-cycle core. It owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake, with up to FIFO_DEPTH requests in flight. Returned words are buffered in an instruction FIFO tagged with their PC. A redirect from execute (branch/jump) flushes buffered and in-flight fetches. It sits between instruction memory and the decoder and lets the core tolerate multi-cycle memory and decode stalls.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 0, fetch PC after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also the in-flight request limit
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  when 0, no new requests are issued; in-flight responses are still accepted
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  word address of request (bits [1:0] = 0)
- imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req)
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  response instruction word
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  XLEN  new fetch PC
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decoder accepts head
- inst_data  out  32  head instruction
- inst_pc  out  XLEN  PC of head instruction
- fetch_misaligned  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: fetch_pc, resp_pc, outstanding count and discard count (each clog2(FIFO_DEPTH+1) bits), FIFO storage {pc, data} with wr/rd pointers and count.
- imem_req = enable & !fetch_misaligned & (fifo_count + outstanding < FIFO_DEPTH); imem_addr = fetch_pc. Both combinational from registers and enable.
- Grant (imem_req & imem_gnt): fetch_pc += 4 (wraps modulo 2^XLEN), outstanding++.
- Response with discard > 0: discard--, outstanding--, word dropped.
- Response with discard = 0: push {resp_pc, imem_rdata}, resp_pc += 4, outstanding--.
- Response with outstanding = 0: protocol violation; ignored, no state change.
- Pop on inst_valid & inst_ready. inst_valid = (fifo_count != 0). inst_data/inst_pc show the head entry.
- Redirect (redirect_valid): FIFO emptied; fetch_pc and resp_pc ← redirect_pc; discard ← outstanding after this cycle's grant/response updates, so a same-cycle grant is discarded and a same-cycle response is dropped; outstanding is unchanged except by those updates. A same-cycle pop completes before the flush.
- Simultaneous push and pop: count unchanged, allowed when full (pop frees the slot first).
- Reset: imem_req 0 while reset is asserted; imem_addr = RESET_PC; inst_valid 0; inst_data 0; inst_pc 0; fetch_misaligned 0; FIFO storage and all counters cleared. Reset mid-transaction abandons in-flight requests: post-reset responses for them hit outstanding = 0 and are ignored.

## Timing
- Redirect in cycle N → imem_addr = redirect_pc in cycle N+1.
- Response in cycle M → inst_valid in cycle M+1 (registered FIFO, no bypass).
- Zero-wait memory (gnt with req, rvalid next cycle), decoder always ready: one instruction per cycle sustained after a 2-cycle fill.
- Decoder stalled: requests stop once fifo_count + outstanding = FIFO_DEPTH. No response is ever lost.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0] != 0 sets fetch_misaligned, performs the flush, and blocks further requests. The flag is cleared only by reset or by a later aligned redirect.
- Not defined: redirect_pc[1:0] is forced to 0, and fetch_misaligned is tied to 0.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory, inst_ready=1 → inst_pc sequence 0,4,8,… with the matching rdata; inst_valid first high 2 cycles after reset deasserts.
- inst_ready=0 for 20 cycles, FIFO_DEPTH=4 → exactly 4 grants, then imem_req=0; inst_ready=1 → entries pc 0,4,8,12 drain in order, and fetching resumes at 16.
- Memory latency 3 with 2 requests in flight, redirect to 0x100 → both old responses dropped; the next inst_pc is 0x100.
- Redirect in the same cycle as a grant and as a pop → the popped entry is consumed once, the granted word is discarded, and the next valid is at the redirect PC.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → fetch_misaligned=1 and imem_req stays 0; a redirect to 0x200 clears the flag and fetches 0x200. Without the macro, the same redirect fetches 0x100.
- Assert reset mid-burst with 3 requests outstanding → outputs at reset values; stray rvalid after release is ignored, and fetch restarts at RESET_PC.
